map_ram_arbiter: RTL
====================

// Module: map_ram_arbiter
// PURPOSE
//   Shares the single-port tile map RAM between the video pipeline (tile reads per pixel) and
//   the game-logic engine (pellet eat/collision reads and writes). Video is latency-critical
//   and has priority; game logic uses a valid/ready handshake and is served in idle cycles.
//   Tags every RAM access so read data returns to the correct requester.
// PARAMETERS
//   TILE_X_W    6   tile column address width (64 columns)
//   TILE_Y_W    5   tile row address width (32 rows)
//   RD_LATENCY  1   map RAM read latency in cycles (1..4)
//   MAX_WAIT    64  game-logic wait cycles before starvation override (STARVE_EN only)
// PORTS
//   i_clk            in   1         system clock
//   i_rst            in   1         reset, asynchronous, active-high
//   i_vid_req        in   1         video tile read request, this cycle
//   i_vid_tile_x     in   TILE_X_W  video tile column
//   i_vid_tile_y     in   TILE_Y_W  video tile row
//   o_vid_valid      out  1         video read data valid
//   o_vid_tile       out  1         video read tile value
//   o_vid_miss       out  1         video read dropped by starvation override
//   i_gl_valid       in   1         game-logic request valid
//   o_gl_ready       out  1         game-logic request accepted this cycle
//   i_gl_write       in   1         1 = write, 0 = read
//   i_gl_tile_x      in   TILE_X_W  game-logic tile column
//   i_gl_tile_y      in   TILE_Y_W  game-logic tile row
//   i_gl_wdata       in   1         write data
//   o_gl_rsp_valid   out  1         game-logic read data valid (reads only)
//   o_gl_rdata       out  1         game-logic read data
//   o_ram_en / o_ram_write / o_ram_tile_x / o_ram_tile_y / o_ram_wdata  out  RAM command
//   i_ram_tile_value in   1         RAM read data, RD_LATENCY after o_ram_en
// BEHAVIOUR
//   - Reset: all outputs 0; wait counter 0; response pipeline cleared. Reset mid-access drops
//     all in-flight responses; no valid is emitted for them after reset release.
//   - Grant (combinational, per cycle): VID if i_vid_req and no override; else GL if i_gl_valid;
//     else NONE. o_gl_ready = (grant == GL). Handshake: request consumed iff valid && ready;
//     requester must hold valid and fields stable until ready.
//   - RAM command mirrors granted requester; o_ram_en = (grant != NONE); o_ram_write only for GL write.
//   - Response pipeline: RD_LATENCY-deep shift of {tag VID/GL_RD/MISS/NONE}; data from
//     i_ram_tile_value routed by tag. o_vid_valid exactly RD_LATENCY cycles after i_vid_req;
//     o_gl_rsp_valid exactly RD_LATENCY cycles after a read handshake. Writes: no response.
//   - Outputs of an idle slot: valid 0, data 0. o_vid_tile/o_gl_rdata 0 when their valid is 0.
//   - Write followed next cycle by read of same tile returns new value (RAM is write-first).
// CONFIGURATION
//   MAP_ARB_STARVE_EN defined: wait_cnt increments each cycle i_gl_valid && !o_gl_ready,
//     saturates at MAX_WAIT; clears on GL handshake or when i_gl_valid is 0. When wait_cnt ==
//     MAX_WAIT, grant goes to GL even if i_vid_req; that video slot is tagged MISS: o_vid_valid 0
//     and o_vid_miss 1 for one cycle, RD_LATENCY cycles later. At most one override per starvation.
//   Not defined: strict video priority, no counter, o_vid_miss tied 0; GL may wait indefinitely.
// STRUCTURE
//   - project package: tile_x_t, tile_y_t typedefs; map_req_t struct {write, x, y, wdata};
//     rsp_tag_e enum {TAG_NONE, TAG_VID, TAG_GL_RD, TAG_MISS}; MAP_TILES_X=64, MAP_TILES_Y=32.
//   - One sub-module: map_rsp_pipe (parameterised RD_LATENCY tag shift register with async clear).
// TESTING
//   - Idle: no requests for 10 cycles -> o_ram_en 0, all valids 0, o_gl_ready 0.
//   - Video only: i_vid_req at (3,5) with RAM value 1 -> o_vid_valid=1, o_vid_tile=1 at +RD_LATENCY.
//   - Contention: vid_req and gl read of (10,2) same cycle -> ready 0; gl served first cycle
//     vid_req drops; o_gl_rsp_valid RD_LATENCY later with RAM value; vid result unaffected.
//   - Write/read: gl write (7,7)=0 then gl read (7,7) -> o_gl_rdata 0, exactly one rsp pulse.
//   - STARVE_EN, MAX_WAIT=4: vid_req held high, gl_valid high -> ready on 5th cycle, o_vid_miss
//     pulse at +RD_LATENCY, counter back to 0; without macro ready never asserts.
//   - Reset asserted between read handshake and its response -> no o_gl_rsp_valid after release.

Source files
------------

// File: rtl/map_ram_arbiter_pkg.sv
// map_ram_arbiter_pkg: shared types for the tile map RAM arbiter.
package map_ram_arbiter_pkg;
    localparam int MAP_TILES_X = 64;
    localparam int MAP_TILES_Y = 32;
    typedef logic [$clog2(MAP_TILES_X)-1:0] tile_x_t;
    typedef logic [$clog2(MAP_TILES_Y)-1:0] tile_y_t;
    typedef struct packed {
        logic    write;
        tile_x_t x;
        tile_y_t y;
        logic    wdata;
    } map_req_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_GL_RD, TAG_MISS} rsp_tag_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_GL} grant_e;
    // gl_rd marks a game-logic read; it travels alongside TAG_MISS when an override slot is a read
    typedef struct packed {
        rsp_tag_e tag;
        logic     gl_rd;
    } rsp_slot_t;
endpackage

// File: rtl/map_ram_arbiter_if.sv
// map_ram_arbiter_if: video, game-logic and RAM command/response signals of the map RAM arbiter.
interface map_ram_arbiter_if #(
    parameter int TILE_X_W = 6,
    parameter int TILE_Y_W = 5
);
    logic                i_vid_req;
    logic [TILE_X_W-1:0] i_vid_tile_x;
    logic [TILE_Y_W-1:0] i_vid_tile_y;
    logic                o_vid_valid;
    logic                o_vid_tile;
    logic                o_vid_miss;
    logic                i_gl_valid;
    logic                o_gl_ready;
    logic                i_gl_write;
    logic [TILE_X_W-1:0] i_gl_tile_x;
    logic [TILE_Y_W-1:0] i_gl_tile_y;
    logic                i_gl_wdata;
    logic                o_gl_rsp_valid;
    logic                o_gl_rdata;
    logic                o_ram_en;
    logic                o_ram_write;
    logic [TILE_X_W-1:0] o_ram_tile_x;
    logic [TILE_Y_W-1:0] o_ram_tile_y;
    logic                o_ram_wdata;
    logic                i_ram_tile_value;

    modport slave (
        input  i_vid_req, i_vid_tile_x, i_vid_tile_y,
        output o_vid_valid, o_vid_tile, o_vid_miss,
        input  i_gl_valid, i_gl_write, i_gl_tile_x, i_gl_tile_y, i_gl_wdata,
        output o_gl_ready, o_gl_rsp_valid, o_gl_rdata,
        output o_ram_en, o_ram_write, o_ram_tile_x, o_ram_tile_y, o_ram_wdata,
        input  i_ram_tile_value
    );

    modport master (
        output i_vid_req, i_vid_tile_x, i_vid_tile_y,
        input  o_vid_valid, o_vid_tile, o_vid_miss,
        output i_gl_valid, i_gl_write, i_gl_tile_x, i_gl_tile_y, i_gl_wdata,
        input  o_gl_ready, o_gl_rsp_valid, o_gl_rdata,
        input  o_ram_en, o_ram_write, o_ram_tile_x, o_ram_tile_y, o_ram_wdata,
        output i_ram_tile_value
    );
endinterface

// File: rtl/map_ram_arbiter_rsp_pipe.sv
// map_rsp_pipe: RD_LATENCY-deep shift register of response tags, cleared asynchronously.
module map_rsp_pipe
    import map_ram_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  rsp_slot_t i_slot,
    output rsp_slot_t o_slot
);
    rsp_slot_t r_pipe [RD_LATENCY];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_slot;
            for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_slot = r_pipe[RD_LATENCY-1];
endmodule

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single-port tile map RAM between video (priority) and game logic.
// Define MAP_ARB_STARVE_EN to let game logic override video after MAX_WAIT stalled cycles.
module map_ram_arbiter
    import map_ram_arbiter_pkg::*;
#(
    parameter int TILE_X_W   = 6,
    parameter int TILE_Y_W   = 5,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 64
) (
    input logic            i_clk,
    input logic            i_rst,
    map_ram_arbiter_if.slave bus
);
    if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_WAIT < 1) begin : g_bad_cfg
        $error("map_ram_arbiter: RD_LATENCY must be 1..4 and MAX_WAIT >= 1");
    end

    grant_e    w_grant;
    logic      w_override;
    map_req_t  w_cmd;
    rsp_slot_t w_slot_in;
    rsp_slot_t w_slot_out;

`ifdef MAP_ARB_STARVE_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_wait_cnt <= '0;
        else if (!bus.i_gl_valid || w_grant == GNT_GL) r_wait_cnt <= '0;
        else if (r_wait_cnt != CNT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    assign w_override     = bus.i_gl_valid && r_wait_cnt == CNT_W'(MAX_WAIT);
    assign bus.o_vid_miss = w_slot_out.tag == TAG_MISS;
`else
    assign w_override     = 1'b0;
    assign bus.o_vid_miss = 1'b0;
`endif

    // reset forces the command bus idle so no access is issued while the pipe is held clear
    assign w_grant = i_rst ? GNT_NONE :
                     (bus.i_vid_req && !w_override) ? GNT_VID :
                     bus.i_gl_valid ? GNT_GL : GNT_NONE;

    always_comb begin
        w_cmd = '0;
        if (w_grant == GNT_VID) begin
            w_cmd.x = tile_x_t'(bus.i_vid_tile_x);
            w_cmd.y = tile_y_t'(bus.i_vid_tile_y);
        end else if (w_grant == GNT_GL) begin
            w_cmd.write = bus.i_gl_write;
            w_cmd.x     = tile_x_t'(bus.i_gl_tile_x);
            w_cmd.y     = tile_y_t'(bus.i_gl_tile_y);
            w_cmd.wdata = bus.i_gl_write & bus.i_gl_wdata;
        end
    end

    assign bus.o_gl_ready   = w_grant == GNT_GL;
    assign bus.o_ram_en     = w_grant != GNT_NONE;
    assign bus.o_ram_write  = w_cmd.write;
    assign bus.o_ram_tile_x = TILE_X_W'(w_cmd.x);
    assign bus.o_ram_tile_y = TILE_Y_W'(w_cmd.y);
    assign bus.o_ram_wdata  = w_cmd.wdata;

    always_comb begin
        w_slot_in       = '0;
        w_slot_in.gl_rd = w_grant == GNT_GL && !bus.i_gl_write;
        w_slot_in.tag   = (w_grant == GNT_GL && bus.i_vid_req) ? TAG_MISS :
                          (w_grant == GNT_VID) ? TAG_VID :
                          w_slot_in.gl_rd ? TAG_GL_RD : TAG_NONE;
    end

    map_rsp_pipe #(.RD_LATENCY(RD_LATENCY)) u_rsp_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_slot (w_slot_in),
        .o_slot (w_slot_out)
    );

    assign bus.o_vid_valid    = w_slot_out.tag == TAG_VID;
    assign bus.o_vid_tile     = bus.o_vid_valid & bus.i_ram_tile_value;
    assign bus.o_gl_rsp_valid = w_slot_out.gl_rd;
    assign bus.o_gl_rdata     = w_slot_out.gl_rd & bus.i_ram_tile_value;
endmodule
